// File: rtl/trap_pkg.sv
// trap_pkg: shared types and constants for the machine-mode trap controller.
//   state_e  : controller FSM states (IDLE, FLUSH, REDIRECT)
//   kind_e   : what the pending redirect is for (TRAP or RET)
//   EXC_*    : bit positions inside the 7-bit exception vector
//   CAUSE_*  : mcause exception codes (4 bits, zero-extended by the consumer)
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    typedef enum logic {
        TRAP = 1'b0,
        RET  = 1'b1
    } kind_e;

    localparam int EXC_LD_MISALIGN   = 0;
    localparam int EXC_LD_ACCESS     = 1;
    localparam int EXC_ST_MISALIGN   = 2;
    localparam int EXC_ST_ACCESS     = 3;
    localparam int EXC_LD_PAGE_FAULT = 4;
    localparam int EXC_ST_PAGE_FAULT = 5;
    localparam int EXC_BREAKPOINT    = 6;

    localparam logic [3:0] CAUSE_BREAKPOINT      = 4'd3;
    localparam logic [3:0] CAUSE_LD_MISALIGN     = 4'd4;
    localparam logic [3:0] CAUSE_LD_ACCESS_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN     = 4'd6;
    localparam logic [3:0] CAUSE_ST_ACCESS_FAULT = 4'd7;
    localparam logic [3:0] CAUSE_LD_PAGE_FAULT   = 4'd13;
    localparam logic [3:0] CAUSE_ST_PAGE_FAULT   = 4'd15;

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: PC redirect handshake from the trap controller to fetch.
//   redirect_valid : redirect request (master -> slave)
//   redirect_pc    : redirect target, stable while valid (master -> slave)
//   redirect_ready : fetch accepts the redirect (slave -> master)
interface trap_ctrl_if #(
    parameter int N = 64
);
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;
    logic         redirect_ready;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/trap_prio.sv
// trap_prio: combinational priority encoder for the exception vector.
//   exc_i    : 7-bit exception vector (bit layout in trap_pkg EXC_*)
//   cause_o  : 4-bit cause code of the highest-priority set bit (0 if none)
//   is_bp_o  : winning cause is the breakpoint
// Priority high to low: breakpoint, store page fault, load page fault,
// store access fault, load access fault, store misaligned, load misaligned.
module trap_prio
    import trap_pkg::*;
(
    input  logic [6:0] exc_i,
    output logic [3:0] cause_o,
    output logic       is_bp_o
);

    always_comb begin
        cause_o = 4'd0;
        is_bp_o = 1'b0;
        if (exc_i[EXC_BREAKPOINT]) begin
            cause_o = CAUSE_BREAKPOINT;
            is_bp_o = 1'b1;
        end else if (exc_i[EXC_ST_PAGE_FAULT]) begin
            cause_o = CAUSE_ST_PAGE_FAULT;
        end else if (exc_i[EXC_LD_PAGE_FAULT]) begin
            cause_o = CAUSE_LD_PAGE_FAULT;
        end else if (exc_i[EXC_ST_ACCESS]) begin
            cause_o = CAUSE_ST_ACCESS_FAULT;
        end else if (exc_i[EXC_LD_ACCESS]) begin
            // load access fault outranks store misaligned (bit1 before bit2)
            cause_o = CAUSE_LD_ACCESS_FAULT;
        end else if (exc_i[EXC_ST_MISALIGN]) begin
            cause_o = CAUSE_ST_MISALIGN;
        end else if (exc_i[EXC_LD_MISALIGN]) begin
            cause_o = CAUSE_LD_MISALIGN;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller.
// Samples the memory-stage exception vector in IDLE, latches mcause/mepc/mtval,
// holds flush for FLUSH_CYCLES cycles, then requests a PC redirect (trap vector
// or saved mepc for mret) over a valid/ready handshake.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   exceptSignal        : 7-bit exception vector
//   except_pc/addr      : faulting PC / data address
//   mret                : mret retiring this cycle
//   mtvec               : trap vector base
//   flush               : pipeline flush
//   rdr (master)        : redirect handshake (valid/pc out, ready in)
//   mcause/mepc/mtval   : latched trap CSRs
//   trap_busy           : controller not idle
// Config macro: TRAP_MTVAL_EN - when defined mtval is captured, otherwise
// mtval reads as zero and no register is built for it.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int N            = 64,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       exceptSignal,
    input  logic [N-1:0]     except_pc,
    input  logic [N-1:0]     except_addr,
    input  logic             mret,
    input  logic [N-1:0]     mtvec,
    output logic             flush,
    trap_ctrl_if.master      rdr,
    output logic [N-1:0]     mcause,
    output logic [N-1:0]     mepc,
    output logic [N-1:0]     mtval,
    output logic             trap_busy
);

    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_FLUSH    = FLUSH;
    localparam logic [1:0] S_REDIRECT = REDIRECT;

    localparam int              CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    kind_e            kind_q, kind_d;
    logic [N-1:0]     mcause_q, mcause_d;
    logic [N-1:0]     mepc_q, mepc_d;
    logic [N-1:0]     rpc_q, rpc_d;

    logic [3:0]       cause;
    logic             is_bp;
    logic             take_exc;

    trap_prio u_prio (
        .exc_i   (exceptSignal),
        .cause_o (cause),
        .is_bp_o (is_bp)
    );

    // Only sampled in IDLE; anything arriving later is being flushed anyway.
    assign take_exc = (state_q == S_IDLE) && (exceptSignal != 7'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        kind_d   = kind_q;
        mcause_d = mcause_q;
        mepc_d   = mepc_q;
        rpc_d    = rpc_q;
        case (state_q)
            S_IDLE: begin
                if (exceptSignal != 7'd0) begin
                    // exception wins over a simultaneous mret
                    mcause_d = N'(cause);
                    mepc_d   = except_pc;
                    kind_d   = TRAP;
                    cnt_d    = CNT_INIT;
                    state_d  = S_FLUSH;
                end else if (mret) begin
                    kind_d  = RET;
                    cnt_d   = CNT_INIT;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    rpc_d   = (kind_q == TRAP) ? {mtvec[N-1:2], 2'b00} : mepc_q;
                    state_d = S_REDIRECT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_REDIRECT: begin
                if (rdr.redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            kind_q   <= TRAP;
            mcause_q <= '0;
            mepc_q   <= '0;
            rpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kind_q   <= kind_d;
            mcause_q <= mcause_d;
            mepc_q   <= mepc_d;
            rpc_q    <= rpc_d;
        end
    end

`ifdef TRAP_MTVAL_EN
    logic [N-1:0] mtval_q, mtval_d;

    // breakpoints report the instruction address, everything else the data address
    always_comb begin
        mtval_d = mtval_q;
        if (take_exc) begin
            mtval_d = is_bp ? except_pc : except_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtval_q <= '0;
        end else begin
            mtval_q <= mtval_d;
        end
    end

    assign mtval = mtval_q;
`else
    logic unused_mtval_inputs;
    assign unused_mtval_inputs = ^{except_addr, is_bp, take_exc};
    assign mtval = '0;
`endif

    // All outputs come straight from state registers.
    assign flush              = (state_q == S_FLUSH);
    assign trap_busy          = (state_q != S_IDLE);
    assign rdr.redirect_valid = (state_q == S_REDIRECT);
    assign rdr.redirect_pc    = rpc_q;
    assign mcause             = mcause_q;
    assign mepc               = mepc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
    localparam int N  = 64;
    localparam int FC = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [6:0]   exceptSignal;
    logic [N-1:0] except_pc, except_addr, mtvec;
    logic         mret;
    logic         flush, trap_busy;
    logic [N-1:0] mcause, mepc, mtval;

    int n_checks = 0;
    int n_fail   = 0;

    // model of architectural trap CSRs
    logic [N-1:0] m_cause, m_epc, m_tval;

    trap_ctrl_if #(.N(N)) rif ();

    trap_ctrl #(.N(N), .FLUSH_CYCLES(FC)) dut (
        .clk          (clk),
        .reset        (reset),
        .exceptSignal (exceptSignal),
        .except_pc    (except_pc),
        .except_addr  (except_addr),
        .mret         (mret),
        .mtvec        (mtvec),
        .flush        (flush),
        .rdr          (rif),
        .mcause       (mcause),
        .mepc         (mepc),
        .mtval        (mtval),
        .trap_busy    (trap_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no end, required summary");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Highest-priority cause from a table walk (bit index, code).
    function automatic int ref_cause(input logic [6:0] e);
        int order [7] = '{6, 5, 4, 3, 1, 2, 0};
        int code  [7] = '{3, 15, 13, 7, 5, 6, 4};
        for (int i = 0; i < 7; i++)
            if (e[order[i]]) return code[i];
        return 0;
    endfunction

    // One complete trap or mret, with 'delay' cycles of redirect backpressure.
    task automatic run_txn(input logic [6:0] exc, input logic [N-1:0] pc,
                           input logic [N-1:0] addr, input logic [N-1:0] vec,
                           input bit m, input int delay, input string tag);
        logic [N-1:0] redir;
        int c;
        int n;
        if (exc != 0) begin
            c       = ref_cause(exc);
            m_cause = N'(c);
            m_epc   = pc;
`ifdef TRAP_MTVAL_EN
            m_tval  = (c == 3) ? pc : addr;
`else
            m_tval  = '0;
`endif
            redir   = {vec[N-1:2], 2'b00};
        end else begin
            redir = m_epc;
        end
        exceptSignal = exc; except_pc = pc; except_addr = addr;
        mret = m; mtvec = vec; rif.redirect_ready = 1'b0;
        cycle();
        exceptSignal = '0; mret = 1'b0;
        n_checks++;
        if (flush !== 1'b1 || trap_busy !== 1'b1 || rif.redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s entry: flush/busy/valid got %b%b%b required 110", tag, flush, trap_busy, rif.redirect_valid);
        end
        n_checks++;
        if (mcause !== m_cause || mepc !== m_epc || mtval !== m_tval) begin
            n_fail++;
            $display("FAIL %s csr: got cause=%0h epc=%0h tval=%0h required cause=%0h epc=%0h tval=%0h",
                     tag, mcause, mepc, mtval, m_cause, m_epc, m_tval);
        end
        // exceptions and mret arriving during flush must be ignored
        n = 0;
        while (flush === 1'b1 && n < 20) begin
            n++;
            exceptSignal = 7'($urandom);
            mret = 1'($urandom);
            cycle();
        end
        exceptSignal = '0; mret = 1'b0;
        n_checks++;
        if (n != FC) begin
            n_fail++;
            $display("FAIL %s flush_len: got %0d required %0d", tag, n, FC);
        end
        n_checks++;
        if (rif.redirect_valid !== 1'b1 || rif.redirect_pc !== redir || trap_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s redirect: got valid=%b pc=%0h required valid=1 pc=%0h", tag, rif.redirect_valid, rif.redirect_pc, redir);
        end
        for (int d = 0; d < delay; d++) begin
            exceptSignal = 7'($urandom);
            mret = 1'($urandom);
            cycle();
            n_checks++;
            if (rif.redirect_valid !== 1'b1 || rif.redirect_pc !== redir || flush !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold: got valid=%b pc=%0h flush=%b required 1 %0h 0", tag, rif.redirect_valid, rif.redirect_pc, flush, redir);
            end
        end
        exceptSignal = '0; mret = 1'b0;
        rif.redirect_ready = 1'b1;
        cycle();
        rif.redirect_ready = 1'b0;
        n_checks++;
        if (rif.redirect_valid !== 1'b0 || trap_busy !== 1'b0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done: valid/busy/flush got %b%b%b required 000", tag, rif.redirect_valid, trap_busy, flush);
        end
        n_checks++;
        if (mcause !== m_cause || mepc !== m_epc || mtval !== m_tval) begin
            n_fail++;
            $display("FAIL %s csr_after: got cause=%0h epc=%0h tval=%0h required %0h %0h %0h",
                     tag, mcause, mepc, mtval, m_cause, m_epc, m_tval);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        exceptSignal = '0; mret = 1'b0; except_pc = '0; except_addr = '0; mtvec = '0;
        rif.redirect_ready = 1'b0;
        m_cause = '0; m_epc = '0; m_tval = '0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        n_checks++;
        if ({flush, rif.redirect_valid, trap_busy} !== 3'b000 || rif.redirect_pc !== '0 ||
            mcause !== '0 || mepc !== '0 || mtval !== '0) begin
            n_fail++;
            $display("FAIL reset: got flush=%b valid=%b busy=%b pc=%0h cause=%0h epc=%0h tval=%0h required all 0",
                     flush, rif.redirect_valid, trap_busy, rif.redirect_pc, mcause, mepc, mtval);
        end
    endtask

    task automatic test_store_misalign();
        run_txn(7'b0000100, 64'h1000, 64'h2003, 64'h8001, 1'b0, 0, "st_misalign");
        n_checks++;
        if (mcause !== 64'd6 || mepc !== 64'h1000) begin
            n_fail++;
            $display("FAIL st_misalign_abs: got cause=%0h epc=%0h required 6 1000", mcause, mepc);
        end
    endtask

    task automatic test_mret();
        run_txn(7'b0, 64'h0, 64'h0, 64'h8001, 1'b1, 0, "mret");
    endtask

    task automatic test_priority();
        run_txn(7'b1000101, 64'h40, 64'h7777, 64'h9000, 1'b1, 0, "priority");
        n_checks++;
        if (mcause !== 64'd3) begin
            n_fail++;
            $display("FAIL priority_abs: got cause=%0h required 3", mcause);
        end
    endtask

    task automatic test_backpressure();
        run_txn(7'b0010000, 64'h3000, 64'h5008, 64'hA000, 1'b0, 5, "backpressure");
    endtask

    task automatic test_back_to_back();
        run_txn(7'b0000010, 64'h10, 64'h20, 64'hB004, 1'b0, 0, "b2b_a");
        run_txn(7'b0100000, 64'h30, 64'h48, 64'hC000, 1'b0, 0, "b2b_b");
        run_txn(7'b0, 64'h0, 64'h0, 64'hC000, 1'b1, 1, "b2b_mret");
    endtask

    task automatic test_reset_mid_flush();
        exceptSignal = 7'b0001000; except_pc = 64'h5550; except_addr = 64'h6660;
        mtvec = 64'hD000; rif.redirect_ready = 1'b1;
        cycle();
        exceptSignal = '0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        m_cause = '0; m_epc = '0; m_tval = '0;
        n_checks++;
        if ({flush, rif.redirect_valid, trap_busy} !== 3'b000 || rif.redirect_pc !== '0 ||
            mcause !== '0 || mepc !== '0 || mtval !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got flush=%b valid=%b busy=%b pc=%0h cause=%0h epc=%0h tval=%0h required all 0",
                     flush, rif.redirect_valid, trap_busy, rif.redirect_pc, mcause, mepc, mtval);
        end
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_checks++;
            if (rif.redirect_valid !== 1'b0 || flush !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_idle: got valid=%b flush=%b required 0 0", rif.redirect_valid, flush);
            end
        end
        rif.redirect_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0] e;
        bit m;
        for (int i = 0; i < 25; i++) begin
            e = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            m = (e == 0) ? 1'b1 : 1'($urandom);
            run_txn(e, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    m, $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        test_reset();
        test_store_misalign();
        test_mret();
        test_priority();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap controller at the consuming end of the memory-stage exception vector. Samples the 7-bit exception vector, selects the highest-priority cause, latches mcause/mepc/mtval, and flushes the pipeline for a fixed number of cycles. It then issues a PC redirect to the trap vector over a valid/ready handshake. It also services mret by redirecting to the saved mepc.

## Interface
- N, 64: datapath/address width
- FLUSH_CYCLES, 3: cycles flush is held high per trap/mret (≥1)
- clk  in  1  system clock; one clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- exceptSignal  in  7  exception vector; bit0 load misaligned, bit1 load access fault, bit2 store misaligned, bit3 store access fault, bit4 load page fault, bit5 store page fault, bit6 breakpoint
- except_pc  in  N  PC of the faulting instruction
- except_addr  in  N  faulting data address
- mret  in  1  mret retiring this cycle
- mtvec  in  N  trap vector base from CSR file
- flush  out  1  pipeline flush
- redirect_valid  out  1  redirect request
- redirect_pc  out  N  redirect target, stable while valid
- redirect_ready  in  1  fetch accepts redirect
- mcause  out  N  latched cause code
- mepc  out  N  latched exception PC
- mtval  out  N  latched trap value
- trap_busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, FLUSH, REDIRECT.
- IDLE, exceptSignal != 0: latch cause, mepc = except_pc, and mtval. Set kind = TRAP, load the flush counter with FLUSH_CYCLES-1, go to FLUSH.
- IDLE, exceptSignal == 0 with mret: set kind = RET, load the counter, go to FLUSH. mcause, mepc and mtval are unchanged.
- Exception and mret in the same cycle: the exception wins and mret is dropped.
- Priority, high to low: bit6 (cause 3), bit5 (15), bit4 (13), bit3 (7), bit1 (5), bit2 (6), bit0 (4). mcause is zero-extended to N bits.
- mtval:
  - Breakpoint: except_pc.
  - All other causes: except_addr.
- FLUSH: flush = 1. The counter decrements each cycle. At 0, latch redirect_pc and go to REDIRECT:
  - TRAP: {mtvec[N-1:2], 2'b00}.
  - RET: mepc.
- REDIRECT: redirect_valid = 1 and redirect_pc is held. When redirect_valid && redirect_ready, go to IDLE.
- exceptSignal and mret are ignored outside IDLE, because those instructions are being flushed.
- Reset values: state IDLE; flush, redirect_valid, trap_busy = 0; redirect_pc, mcause, mepc, mtval = 0; counter = 0.
- Reset mid-trap (any state) aborts immediately to reset values. No partial redirect is issued.

## Timing
- Cycle T: exceptSignal nonzero in IDLE.
- T+1: mcause/mepc/mtval show new values; flush = 1; trap_busy = 1.
- flush stays high for exactly FLUSH_CYCLES cycles (T+1 .. T+FLUSH_CYCLES).
- T+FLUSH_CYCLES+1: redirect_valid = 1. Minimum latency from exception to redirect is FLUSH_CYCLES+1 cycles.
- If redirect_ready is high on the first REDIRECT cycle, the handshake completes that cycle. IDLE follows on the next cycle, and a new exception is accepted there.
- redirect_ready low: redirect_valid and redirect_pc hold indefinitely. flush stays low.
- Outputs are registered; no combinational path from any input to any output.

## Configuration
- TRAP_MTVAL_EN defined: mtval is captured as described above.
- TRAP_MTVAL_EN undefined: the mtval register is not built and mtval is tied to 0. All other behaviour and timing are identical.

## Structure
- Package trap_pkg holds:
  - state enum {IDLE, FLUSH, REDIRECT}
  - kind enum {TRAP, RET}
  - exception bit-index constants (EXC_LD_MISALIGN … EXC_BREAKPOINT)
  - cause code constants (CAUSE_BREAKPOINT = 3 … CAUSE_ST_PAGE_FAULT = 15)
- Sub-module trap_prio: combinational priority encoder from the 7-bit vector to a 4-bit cause plus an is_breakpoint flag. The FSM and registers live in trap_ctrl.

## Test plan
- Store misaligned: exceptSignal = 7'b0000100, except_pc = 0x1000, except_addr = 0x2003, mtvec = 0x8001, FLUSH_CYCLES = 3 -> mcause = 6, mepc = 0x1000, mtval = 0x2003; flush high 3 cycles; redirect_pc = 0x8000 on cycle 4.
- Priority: exceptSignal = 7'b1000101 with except_pc = 0x40 -> mcause = 3, mtval = 0x40; simultaneous mret ignored.
- mret after a trap: mret pulse in IDLE -> 3 flush cycles, then redirect_pc = the saved mepc 0x1000; mcause unchanged.
- Backpressure: redirect_ready low for 5 cycles -> redirect_valid and redirect_pc stable and flush low throughout; exceptSignal pulses during the wait are ignored.
- Reset during FLUSH (second cycle) -> the next cycle shows every output at 0, state IDLE, and no redirect is issued.
- TRAP_MTVAL_EN undefined: repeat the first test -> mtval = 0; all other results identical.
